sync_fifo: RTL

Parametrised single-clock FIFO, the successor to the team's fixed 8x8 addressed memory with full/empty tracking. It replaces caller-supplied addresses with internal wrap-around read/write pointers and an occupancy counter. It adds almost-full/almost-empty thresholds, simultaneous read/write, sticky overflow/underflow error flags and a synchronous flush. It sits between a producer and a consumer in the same clock domain, as the standard buffering element of the lab designs.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ram.sv | 39 +++
 rtl/sync_fifo.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 8;

  // Ceiling log2 usable in constant expressions; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  localparam int unsigned DEF_CNT_W = clog2(DEF_DEPTH) + 1;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, registered read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Array is deliberately unreset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy counter, threshold flags, sticky errors.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AF_TH  = DEPTH - 2,
  parameter int unsigned AE_TH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full_flag,
  output logic                   empty_flag,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW    = clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end
  if ((AE_TH >= AF_TH) || (AF_TH > DEPTH)) begin : g_bad_thresholds
    $error("sync_fifo: thresholds must satisfy AE_TH < AF_TH <= DEPTH");
  end

  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow, r_underflow;

  logic [AW-1:0]    w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_overflow_nxt, w_underflow_nxt;
  logic             w_full, w_empty, w_wr_acc, w_rd_acc;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Full FIFO still takes a write when a read frees a slot in the same edge.
  assign w_wr_acc = wr_en && (!w_full || rd_en) && !clear;
  assign w_rd_acc = rd_en && !w_empty && !clear;

  always_comb begin
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_count_nxt     = r_count;
    w_overflow_nxt  = r_overflow;
    w_underflow_nxt = r_underflow;
    if (clear) begin
      w_wr_ptr_nxt    = '0;
      w_rd_ptr_nxt    = '0;
      w_count_nxt     = '0;
      w_overflow_nxt  = 1'b0;
      w_underflow_nxt = 1'b0;
    end else begin
      if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
      if (wr_en && !w_wr_acc) w_overflow_nxt  = 1'b1;
      if (rd_en && !w_rd_acc) w_underflow_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr),
    .wr_data (data_in),
    .rd_en   (w_rd_acc),
    .rd_addr (r_rd_ptr),
    .rd_data (data_out)
  );

  // Status flags decode the registered count directly.
  assign count        = r_count;
  assign full_flag    = w_full;
  assign empty_flag   = w_empty;
  assign almost_full  = (r_count >= CNT_W'(AF_TH));
  assign almost_empty = (r_count <= CNT_W'(AE_TH));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
